// File: rtl/cve2_lsu_resp_align_pkg.sv
// Shared types for the LSU response collector: FSM states, data-type encoding
// and the misaligned-split rule.
package cve2_lsu_resp_align_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE        = 2'b00,
        WAIT_FIRST  = 2'b01,
        WAIT_SECOND = 2'b10
    } lsu_resp_state_e;

    // 2'b1x is byte
    localparam logic [1:0] TYPE_WORD = 2'b00;
    localparam logic [1:0] TYPE_HALF = 2'b01;

    function automatic logic needs_split(input logic [1:0] dtype, input logic [1:0] offset);
        return ((dtype == TYPE_WORD) && (offset != 2'd0)) ||
               ((dtype == TYPE_HALF) && (offset == 2'd3));
    endfunction

endpackage

// File: rtl/cve2_lsu_resp_align_load_extend.sv
// Combinational load-data alignment and sign/zero extension.
module cve2_load_extend
    import cve2_lsu_resp_align_pkg::*;
(
    input  logic [1:0]        i_type,
    input  logic              i_sign_ext,
    input  logic [1:0]        i_offset,
    input  logic              i_split,
    input  logic [DATA_W-1:0] i_partial,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [DATA_W-1:0] o_data
);

    logic [4:0]        w_shr;
    logic [4:0]        w_shl;
    logic [DATA_W-1:0] w_field;

    assign w_shr = {i_offset, 3'b000};
    // Second beat fills in above the partial; offset 0 never splits
    assign w_shl = 5'(6'd32 - 6'({i_offset, 3'b000}));

    assign w_field = i_split ? (i_partial | (i_rdata << w_shl)) : (i_rdata >> w_shr);

    always_comb begin
        o_data = w_field;
        case (i_type)
            TYPE_WORD: o_data = w_field;
            TYPE_HALF: o_data = {{16{i_sign_ext & w_field[15]}}, w_field[15:0]};
            default:   o_data = {{24{i_sign_ext & w_field[7]}}, w_field[7:0]};
        endcase
    end

endmodule

// File: rtl/cve2_lsu_resp_align.sv
// Tracks one outstanding LSU transaction, merges split responses and delivers
// a registered single-cycle result to writeback.
module cve2_lsu_resp_align
    import cve2_lsu_resp_align_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              lsu_req_i,
    input  logic              lsu_we_i,
    input  logic [1:0]        lsu_type_i,
    input  logic              lsu_sign_ext_i,
    input  logic [1:0]        lsu_addr_offset_i,
    input  logic              data_rvalid_i,
    input  logic [DATA_W-1:0] data_rdata_i,
    input  logic              data_err_i,
    output logic              ready_o,
    output logic              busy_o,
    output logic [DATA_W-1:0] rf_wdata_lsu_o,
    output logic              rf_we_lsu_o,
    output logic              lsu_resp_valid_o,
    output logic              lsu_resp_err_o
);

    lsu_resp_state_e   r_state;
    lsu_resp_state_e   w_state_nxt;
    logic              r_we;
    logic [1:0]        r_type;
    logic              r_sign_ext;
    logic [1:0]        r_offset;
    logic              r_split;
    logic [DATA_W-1:0] r_partial;
    logic              r_err1;
    logic              r_resp_valid;
    logic              r_resp_err;
    logic              r_rf_we;
    logic [DATA_W-1:0] r_rf_wdata;

    logic              w_accept;
    logic              w_first;
    logic              w_finish;
    logic              w_err_nxt;
    logic              w_we_nxt;
    logic [DATA_W-1:0] w_wdata_nxt;
    logic [DATA_W-1:0] w_ext;
    logic [DATA_W-1:0] w_partial_nxt;

    assign w_partial_nxt = data_rdata_i >> {r_offset, 3'b000};

    cve2_load_extend u_load_extend (
        .i_type     (r_type),
        .i_sign_ext (r_sign_ext),
        .i_offset   (r_offset),
        .i_split    (r_split),
        .i_partial  (r_partial),
        .i_rdata    (data_rdata_i),
        .o_data     (w_ext)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_first     = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (lsu_req_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = WAIT_FIRST;
                end
            end
            WAIT_FIRST: begin
                if (data_rvalid_i) begin
                    if (r_split) begin
                        w_first     = 1'b1;
                        w_state_nxt = WAIT_SECOND;
                    end else begin
                        w_finish    = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            WAIT_SECOND: begin
                if (data_rvalid_i) begin
                    w_finish    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_err_nxt   = w_finish & (r_err1 | data_err_i);
        w_we_nxt    = w_finish & ~r_we & ~w_err_nxt;
        w_wdata_nxt = w_we_nxt ? w_ext : '0;
    end

    // Capture registers and first-beat partial data
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_we       <= 1'b0;
            r_type     <= TYPE_WORD;
            r_sign_ext <= 1'b0;
            r_offset   <= 2'd0;
            r_split    <= 1'b0;
            r_partial  <= '0;
            r_err1     <= 1'b0;
        end else if (w_accept) begin
            r_we       <= lsu_we_i;
            r_type     <= lsu_type_i;
            r_sign_ext <= lsu_sign_ext_i;
            r_offset   <= lsu_addr_offset_i;
            r_split    <= needs_split(lsu_type_i, lsu_addr_offset_i);
            r_partial  <= '0;
            r_err1     <= 1'b0;
        end else if (w_first) begin
            r_partial  <= w_partial_nxt;
            r_err1     <= data_err_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_rf_we      <= 1'b0;
            r_rf_wdata   <= '0;
        end else begin
            r_resp_valid <= w_finish;
            r_resp_err   <= w_err_nxt;
            r_rf_we      <= w_we_nxt;
            r_rf_wdata   <= w_wdata_nxt;
        end
    end

    assign ready_o          = (r_state == IDLE);
    assign busy_o           = (r_state != IDLE);
    assign lsu_resp_valid_o = r_resp_valid;
    assign lsu_resp_err_o   = r_resp_err;
    assign rf_we_lsu_o      = r_rf_we;
    assign rf_wdata_lsu_o   = r_rf_wdata;

endmodule

// File: tb/tb_cve2_lsu_resp_align.sv
// Scoreboard bench for cve2_lsu_resp_align: expected results queued when the
// final response is driven, compared when the registered pulse appears.
module tb_cve2_lsu_resp_align;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        lsu_req_i = 1'b0;
    logic        lsu_we_i = 1'b0;
    logic [1:0]  lsu_type_i = 2'b00;
    logic        lsu_sign_ext_i = 1'b0;
    logic [1:0]  lsu_addr_offset_i = 2'b00;
    logic        data_rvalid_i = 1'b0;
    logic [31:0] data_rdata_i = '0;
    logic        data_err_i = 1'b0;
    logic        ready_o;
    logic        busy_o;
    logic [31:0] rf_wdata_lsu_o;
    logic        rf_we_lsu_o;
    logic        lsu_resp_valid_o;
    logic        lsu_resp_err_o;

    int n_pass  = 0;
    int n_total = 0;

    // {valid, err, we, wdata}
    logic [34:0] sb[$];
    logic [34:0] exp_v;
    logic [34:0] got;
    assign got = {lsu_resp_valid_o, lsu_resp_err_o, rf_we_lsu_o, rf_wdata_lsu_o};

    always #5 clk_i = ~clk_i;

    cve2_lsu_resp_align dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .lsu_req_i         (lsu_req_i),
        .lsu_we_i          (lsu_we_i),
        .lsu_type_i        (lsu_type_i),
        .lsu_sign_ext_i    (lsu_sign_ext_i),
        .lsu_addr_offset_i (lsu_addr_offset_i),
        .data_rvalid_i     (data_rvalid_i),
        .data_rdata_i      (data_rdata_i),
        .data_err_i        (data_err_i),
        .ready_o           (ready_o),
        .busy_o            (busy_o),
        .rf_wdata_lsu_o    (rf_wdata_lsu_o),
        .rf_we_lsu_o       (rf_we_lsu_o),
        .lsu_resp_valid_o  (lsu_resp_valid_o),
        .lsu_resp_err_o    (lsu_resp_err_o)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic we, input logic [1:0] t, input logic sx, input logic [1:0] off);
        lsu_req_i = 1'b1; lsu_we_i = we; lsu_type_i = t;
        lsu_sign_ext_i = sx; lsu_addr_offset_i = off;
        step();
        lsu_req_i = 1'b0;
    endtask

    task automatic respond(input logic [31:0] d, input logic e);
        data_rvalid_i = 1'b1; data_rdata_i = d; data_err_i = e;
        step();
        data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rdata_i = '0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step(); step();
        rst_i = 1'b0;
        n_total++;
        if ({ready_o, busy_o, got} !== {2'b10, 35'd0})
            $display("FAIL reset: got ready=%b busy=%b out=%h, want ready=1 busy=0 out=0", ready_o, busy_o, got);
        else n_pass++;
    endtask

    task automatic test_word_aligned();
        issue(1'b0, 2'b00, 1'b0, 2'd0);
        sb.push_back({3'b101, 32'hDEADBEEF});
        respond(32'hDEADBEEF, 1'b0);
        exp_v = sb.pop_front();
        n_total++;
        if (got !== exp_v) $display("FAIL word_aligned: got %h want %h", got, exp_v);
        else n_pass++;
        step();
        n_total++;
        if (got !== 35'd0) $display("FAIL word_aligned_idle: got %h want 0", got);
        else n_pass++;
    endtask

    task automatic test_byte_ext();
        issue(1'b0, 2'b10, 1'b1, 2'd2);
        sb.push_back({3'b101, 32'hFFFFFF80});
        respond(32'h00800000, 1'b0);
        exp_v = sb.pop_front();
        n_total++;
        if (got !== exp_v) $display("FAIL byte_sext: got %h want %h", got, exp_v);
        else n_pass++;
        issue(1'b0, 2'b11, 1'b0, 2'd2);
        sb.push_back({3'b101, 32'h00000080});
        respond(32'h00800000, 1'b0);
        exp_v = sb.pop_front();
        n_total++;
        if (got !== exp_v) $display("FAIL byte_zext: got %h want %h", got, exp_v);
        else n_pass++;
    endtask

    task automatic test_split_word();
        int pulses;
        issue(1'b0, 2'b00, 1'b0, 2'd1);
        respond(32'h44332211, 1'b0);
        n_total++;
        if ({busy_o, lsu_resp_valid_o} !== 2'b10)
            $display("FAIL split_word_mid: got busy=%b valid=%b want busy=1 valid=0", busy_o, lsu_resp_valid_o);
        else n_pass++;
        step();
        sb.push_back({3'b101, 32'h55443322});
        respond(32'h88776655, 1'b0);
        exp_v = sb.pop_front();
        n_total++;
        if (got !== exp_v) $display("FAIL split_word: got %h want %h", got, exp_v);
        else n_pass++;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (lsu_resp_valid_o) pulses++;
        end
        n_total++;
        if (pulses != 0) $display("FAIL split_word_single_pulse: got %0d extra pulses want 0", pulses);
        else n_pass++;
    endtask

    task automatic test_split_half();
        issue(1'b0, 2'b01, 1'b1, 2'd3);
        respond(32'hAB000000, 1'b0);
        sb.push_back({3'b101, 32'hFFFFCDAB});
        respond(32'h000000CD, 1'b0);
        exp_v = sb.pop_front();
        n_total++;
        if (got !== exp_v) $display("FAIL split_half: got %h want %h", got, exp_v);
        else n_pass++;
    endtask

    task automatic test_split_err();
        issue(1'b0, 2'b00, 1'b0, 2'd2);
        respond(32'h12345678, 1'b1);
        n_total++;
        if ({busy_o, lsu_resp_valid_o} !== 2'b10)
            $display("FAIL split_err_no_abort: got busy=%b valid=%b want busy=1 valid=0", busy_o, lsu_resp_valid_o);
        else n_pass++;
        sb.push_back({3'b110, 32'h0});
        respond(32'h9ABCDEF0, 1'b0);
        exp_v = sb.pop_front();
        n_total++;
        if (got !== exp_v) $display("FAIL split_err: got %h want %h", got, exp_v);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 2'b00, 1'b0, 2'd0);
        sb.push_back({3'b100, 32'h0});
        respond(32'hFFFFFFFF, 1'b0);
        exp_v = sb.pop_front();
        n_total++;
        if ({ready_o, got} !== {1'b1, exp_v}) $display("FAIL store: got ready=%b out=%h want ready=1 out=%h", ready_o, got, exp_v);
        else n_pass++;
        issue(1'b0, 2'b01, 1'b0, 2'd2);
        n_total++;
        if (busy_o !== 1'b1) $display("FAIL b2b_accept: got busy=%b want 1", busy_o);
        else n_pass++;
        sb.push_back({3'b101, 32'h0000F00D});
        respond(32'hF00D1234, 1'b0);
        exp_v = sb.pop_front();
        n_total++;
        if (got !== exp_v) $display("FAIL b2b_load: got %h want %h", got, exp_v);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        issue(1'b0, 2'b00, 1'b0, 2'd3);
        respond(32'h11223344, 1'b0);
        rst_i = 1'b1;
        data_rvalid_i = 1'b1; data_rdata_i = 32'h55667788;
        step();
        rst_i = 1'b0;
        data_rvalid_i = 1'b0;
        n_total++;
        if ({ready_o, got} !== {1'b1, 35'd0}) $display("FAIL reset_mid: got ready=%b out=%h want ready=1 out=0", ready_o, got);
        else n_pass++;
        respond(32'hCAFEBABE, 1'b0);
        n_total++;
        if ({ready_o, got} !== {1'b1, 35'd0}) $display("FAIL reset_mid_rvalid_ignored: got ready=%b out=%h want ready=1 out=0", ready_o, got);
        else n_pass++;
    endtask

    task automatic test_random_aligned();
        logic [31:0] d;
        logic [1:0]  t;
        logic [1:0]  off;
        logic        sx;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] e;
        for (int i = 0; i < 8; i++) begin
            d   = $urandom;
            t   = (i % 2 == 0) ? 2'b10 : 2'b01;
            off = 2'($urandom_range(0, (t == 2'b01) ? 2 : 3));
            sx  = 1'($urandom_range(0, 1));
            b   = d[8*off +: 8];
            h   = d[8*off +: 16];
            if (t == 2'b01) e = sx ? {{16{h[15]}}, h} : {16'h0, h};
            else            e = sx ? {{24{b[7]}}, b}  : {24'h0, b};
            issue(1'b0, t, sx, off);
            sb.push_back({3'b101, e});
            respond(d, 1'b0);
            exp_v = sb.pop_front();
            n_total++;
            if (got !== exp_v) $display("FAIL rand_aligned[%0d]: got %h want %h", i, got, exp_v);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_word_aligned();
        test_byte_ext();
        test_split_word();
        test_split_half();
        test_split_err();
        test_back_to_back();
        test_reset_mid();
        test_random_aligned();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cve2_lsu_resp_align.md
Name: cve2_lsu_resp_align

Overview:
Load/store response collector between the data bus and the writeback stage. Tracks one outstanding LSU transaction. Merges the two bus responses of a misaligned access, then aligns and sign/zero-extends load data. Delivers a registered, single-cycle result to writeback on rf_wdata_lsu/rf_we_lsu/lsu_resp_valid/lsu_resp_err.

Parameters:
None.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
lsu_req_i  in  1  transaction issued by ID/EX this cycle; accepted only when ready_o=1
lsu_we_i  in  1  1=store, 0=load
lsu_type_i  in  2  00 word, 01 half, 1x byte
lsu_sign_ext_i  in  1  sign-extend load result
lsu_addr_offset_i  in  2  address bits [1:0]
data_rvalid_i  in  1  bus response valid
data_rdata_i  in  32  bus read data (word-aligned)
data_err_i  in  1  bus error, qualified by data_rvalid_i
ready_o  out  1  state==IDLE
busy_o  out  1  transaction outstanding (state!=IDLE)
rf_wdata_lsu_o  out  32  aligned/extended load data
rf_we_lsu_o  out  1  load result write enable
lsu_resp_valid_o  out  1  transaction complete pulse
lsu_resp_err_o  out  1  transaction completed with error

Behaviour:
- Reset (rst_i=1 at clk_i edge): state=IDLE; all outputs 0; captured fields, partial data and error flag cleared. Reset mid-transaction discards it, and no response is emitted.
- Split rule: a transaction needs two responses if type=word with offset!=0, or type=half with offset=3. Byte accesses never split.
- State machine:
  - IDLE: on lsu_req_i, capture we/type/sign_ext/offset/split, then go to WAIT_FIRST. data_rvalid_i is ignored in IDLE.
  - WAIT_FIRST: on data_rvalid_i with split=1, store rdata[31:8*offset] in a partial register, store err1=data_err_i, then go to WAIT_SECOND. On data_rvalid_i with split=0, finish and go to IDLE.
  - WAIT_SECOND: on data_rvalid_i, finish and go to IDLE.
- lsu_req_i is ignored when ready_o=0.
- A new lsu_req_i is accepted in the cycle after the final response, while the result pulse is on the outputs.
- Finish: outputs are registered and appear the cycle after the final data_rvalid_i, held for exactly one cycle.
  - lsu_resp_valid_o=1
  - lsu_resp_err_o = err1 | final data_err_i (err1=0 for non-split)
  - rf_we_lsu_o = ~we & ~lsu_resp_err_o
  - rf_wdata_lsu_o = extended load data when rf_we_lsu_o=1, else 0
- Load alignment:
  - Non-split: field = rdata >> (8*offset).
  - Split word: {rdata2[8*offset-1:0], partial}, giving 32 bits.
  - Split half (offset 3): {rdata2[7:0], partial[7:0]}.
- Extension: byte uses bit 7 and half uses bit 15 as the sign when sign_ext=1; otherwise zero-extend. Word is passed through.
- Errors: an error on the first half of a split still waits for the second response before completing. There is no early abort.
- Stores: data is ignored and rf_we_lsu_o=0; the completion pulse still occurs.
- Invariant: rf_we_lsu_o implies lsu_resp_valid_o. At most one completion per accepted request.

Decomposition:
- cve2_pkg additions:
  - lsu_resp_state_e {IDLE, WAIT_FIRST, WAIT_SECOND}
  - reuse the 2-bit data-type encoding (word/half/byte)
- Sub-module cve2_load_extend: purely combinational. Inputs: type, sign_ext, offset, split, partial, rdata. Output: 32-bit extended data. The FSM, capture registers and output registers stay in the top.

Test Plan:
- Aligned word load, offset 0, rdata=0xDEADBEEF -> one cycle after rvalid: resp_valid=1, rf_we=1, rf_wdata=0xDEADBEEF; all 0 the following cycle.
- Byte load, offset 2, sign_ext=1, rdata=0x00800000 -> rf_wdata=0xFFFFFF80. Same with sign_ext=0 -> 0x00000080.
- Misaligned word, offset 1: rdata1=0x44332211, rdata2=0x88776655 -> rf_wdata=0x55443322. busy_o=1 between the two responses, and only one resp_valid pulse.
- Misaligned half, offset 3, sign_ext=1: rdata1=0xAB000000, rdata2=0x000000CD -> rf_wdata=0xFFFFCDAB.
- Split word with data_err_i=1 on the first response only -> completes after the second response with resp_err=1, rf_we=0, rf_wdata=0.
- Store, then lsu_req_i in the completion cycle; rst_i asserted in WAIT_SECOND:
  - Store completes with resp_valid=1, rf_we=0; the back-to-back request is accepted.
  - After reset: no resp_valid, ready_o=1, and a following rvalid is ignored.
